// File: rtl/debug_host_link.sv
// Host-side UART debug link: sends a command byte, then gathers little-endian response words.
// Optional build macro DEBUG_HOST_CHECKSUM_EN adds a trailing XOR checksum byte and o_checksum_err.
module debug_host_link #(
  parameter int NB             = 32,
  parameter int DATA_BITS      = 8,
  parameter int MAX_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_cmd_valid,
  input  logic [DATA_BITS-1:0]           i_cmd_byte,
  input  logic [$clog2(MAX_WORDS+1)-1:0] i_cmd_words,
  output logic                           o_uart_tx_ready,
  output logic [DATA_BITS-1:0]           o_uart_tx_data,
  input  logic                           i_uart_tx_done,
  input  logic                           i_uart_rx_ready,
  input  logic [DATA_BITS-1:0]           i_uart_rx_data,
  output logic                           o_word_valid,
  output logic [NB-1:0]                  o_word,
  output logic [$clog2(MAX_WORDS)-1:0]   o_word_index,
  output logic                           o_busy,
  output logic                           o_done,
`ifdef DEBUG_HOST_CHECKSUM_EN
  output logic                           o_checksum_err,
`endif
  output logic                           o_timeout
);

  localparam int CW  = $clog2(MAX_WORDS + 1);
  localparam int IW  = $clog2(MAX_WORDS);
  localparam int BPW = NB / DATA_BITS;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_RECV,
`ifdef DEBUG_HOST_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cmd_words_q;
  logic [CW-1:0]   words_clamped;
  logic [CW-1:0]   word_cnt;
  logic [BCW-1:0]  byte_cnt;
  logic [NB-1:0]   shift_q;
  logic [NB-1:0]   assembled;
  logic [TW-1:0]   tmo_cnt;
  logic            byte_last;
  logic            word_last;
  logic            tmo_hit;
  logic            counting;
  logic            accept;
  logic            word_done;
  logic            finish;
  logic            abort;
`ifdef DEBUG_HOST_CHECKSUM_EN
  logic [DATA_BITS-1:0] csum;
  logic                 chk_bad;
`endif

  // The incoming byte is merged into the partial word at its little-endian slot.
  always_comb begin
    words_clamped = (i_cmd_words > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : i_cmd_words;
    byte_last     = (byte_cnt == BCW'(BPW - 1));
    word_last     = (word_cnt == cmd_words_q - CW'(1));
    tmo_hit       = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assembled     = shift_q;
    assembled[byte_cnt*DATA_BITS +: DATA_BITS] = i_uart_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    o_uart_tx_ready = 1'b0;
    accept          = 1'b0;
    word_done       = 1'b0;
    finish          = 1'b0;
    abort           = 1'b0;
    counting        = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        o_uart_tx_ready = 1'b1;
        state_nxt       = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_uart_tx_done) state_nxt = (cmd_words_q == '0) ? S_FIN : S_RECV;
      end
      S_RECV: begin
        counting = 1'b1;
        if (i_uart_rx_ready) begin
          if (byte_last) begin
            word_done = 1'b1;
            if (word_last) begin
`ifdef DEBUG_HOST_CHECKSUM_EN
              state_nxt = S_CHK;
`else
              state_nxt = S_FIN;
`endif
            end
          end
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`ifdef DEBUG_HOST_CHECKSUM_EN
      S_CHK: begin
        counting = 1'b1;
        if (i_uart_rx_ready) begin
          state_nxt = S_FIN;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`endif
      S_FIN: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status pulses are registered, so o_done lands the cycle after FIN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_uart_tx_data <= '0;
      o_word_valid   <= 1'b0;
      o_word         <= '0;
      o_word_index   <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_timeout      <= 1'b0;
      cmd_words_q    <= '0;
      word_cnt       <= '0;
      byte_cnt       <= '0;
      shift_q        <= '0;
      tmo_cnt        <= '0;
`ifdef DEBUG_HOST_CHECKSUM_EN
      o_checksum_err <= 1'b0;
      csum           <= '0;
      chk_bad        <= 1'b0;
`endif
    end else begin
      o_word_valid <= word_done;
      o_done       <= finish;
      o_timeout    <= abort;
`ifdef DEBUG_HOST_CHECKSUM_EN
      o_checksum_err <= finish & chk_bad;
`endif
      if (accept) begin
        o_uart_tx_data <= i_cmd_byte;
        cmd_words_q    <= words_clamped;
        o_busy         <= 1'b1;
        word_cnt       <= '0;
        byte_cnt       <= '0;
`ifdef DEBUG_HOST_CHECKSUM_EN
        csum           <= '0;
        chk_bad        <= 1'b0;
`endif
      end else if (finish || abort) begin
        o_busy <= 1'b0;
      end

      if (counting && !i_uart_rx_ready && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
      else                                          tmo_cnt <= '0;

      if (state == S_RECV && i_uart_rx_ready) begin
        shift_q <= assembled;
`ifdef DEBUG_HOST_CHECKSUM_EN
        csum    <= csum ^ i_uart_rx_data;
`endif
        if (byte_last) begin
          byte_cnt     <= '0;
          word_cnt     <= word_cnt + CW'(1);
          o_word       <= assembled;
          o_word_index <= word_cnt[IW-1:0];
        end else begin
          byte_cnt <= byte_cnt + BCW'(1);
        end
      end

`ifdef DEBUG_HOST_CHECKSUM_EN
      if (state == S_CHK && i_uart_rx_ready) chk_bad <= (i_uart_rx_data != csum);
`endif

      if (abort) byte_cnt <= '0;
    end
  end

endmodule

// File: doc/debug_host_link.md
Name: debug_host_link

Overview:
- Host-side counterpart of the UART debug unit: issues a one-byte command over the UART transmitter, then collects the debug unit's response bytes from the UART receiver.
- Reassembles the response bytes into NB-bit words (PC, register, memory, ALU result) and presents them on a valid strobe.
- Used as a hardware host model in system benches and in loopback builds; sits between the Receptor/Transmisor pair and a command source (bench or on-chip sequencer).

Parameters:
- NB, 32, response word width in bits; must be a multiple of DATA_BITS.
- DATA_BITS, 8, UART byte width.
- MAX_WORDS, 64, largest response length accepted per command.
- TIMEOUT_CYCLES, 2000000, idle clock cycles allowed between received bytes before a response is aborted.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset; one clock, synchronous, active-high.
- i_cmd_valid  in  1  command request; accepted only when o_busy=0.
- i_cmd_byte  in  DATA_BITS  command code sent to the debug unit.
- i_cmd_words  in  $clog2(MAX_WORDS+1)  number of response words expected; values above MAX_WORDS are clamped to MAX_WORDS.
- o_uart_tx_ready  out  1  single-cycle start pulse to the transmitter.
- o_uart_tx_data  out  DATA_BITS  byte to transmit; held stable from the start pulse until tx done.
- i_uart_tx_done  in  1  transmitter byte-complete pulse.
- i_uart_rx_ready  in  1  receiver byte-valid pulse.
- i_uart_rx_data  in  DATA_BITS  received byte.
- o_word_valid  out  1  single-cycle pulse when a full word has been assembled.
- o_word  out  NB  assembled word; held until the next word is assembled.
- o_word_index  out  $clog2(MAX_WORDS)  index of o_word within the response, starting at 0.
- o_busy  out  1  high from command acceptance until the response completes or times out.
- o_done  out  1  single-cycle pulse when the response completes.
- o_timeout  out  1  single-cycle pulse when a response is aborted on timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- FSM states and transitions:
  - IDLE: when i_cmd_valid=1, latch the command byte and the (clamped) word count, set o_busy=1, go to SEND.
  - SEND: drive o_uart_tx_ready=1 for exactly one cycle with o_uart_tx_data=command byte, then go to WAIT_TX.
  - WAIT_TX: wait for i_uart_tx_done. On done: if word count = 0, go to FIN; otherwise go to RECV.
  - RECV: shift in bytes; a word is complete after NB/DATA_BITS bytes. When the last word completes, go to FIN.
  - FIN: pulse o_done for one cycle, clear o_busy, return to IDLE.
- Byte order: little-endian; the first received byte of each word becomes o_word[DATA_BITS-1:0].
- Word output latency: o_word_valid rises the cycle after the i_uart_rx_ready that carries the last byte of the word. o_word and o_word_index update in that same cycle.
- Bytes arriving outside RECV (IDLE, SEND, WAIT_TX) are discarded.
- Timeout:
  - The timeout counter runs only in RECV and clears on every i_uart_rx_ready.
  - When the counter reaches TIMEOUT_CYCLES-1: pulse o_timeout, discard any partial word, clear o_busy, go to IDLE. No o_done pulse is issued.
- i_cmd_valid while o_busy=1 is ignored; the command is not queued.
- i_uart_rx_ready and the timeout expiring in the same cycle: the byte wins and the counter clears.
- Reset asserted mid-operation: return to IDLE on the next edge. No o_done or o_timeout pulse is issued. The transmitter is not told to abort.

Optional Feature:
- Macro: DEBUG_HOST_CHECKSUM_EN.
- When defined:
  - After the last word, one extra byte is expected: the XOR of all response bytes.
  - An extra state CHK handles this byte, and a port o_checksum_err (out, 1) is added.
  - On mismatch, o_checksum_err pulses in the same cycle as o_done.
  - A timeout while waiting for the checksum byte behaves like a timeout in RECV.
- When not defined: no CHK state, no extra port; FIN follows the last word directly.

Test Plan:
- Command 0x01, words=1; rx bytes 0x04,0x00,0x00,0x00 -> o_word=0x00000004, index 0, o_word_valid pulses once, then o_done pulses one cycle later, o_busy falls.
- Command 0x02, words=3; rx 12 bytes 0x00..0x0B -> words 0x03020100, 0x07060504, 0x0B0A0908 at indices 0, 1, 2; exactly one o_done.
- Words=0; command 0x10 -> exactly one tx start pulse with o_uart_tx_data=0x10; o_done the cycle after tx_done enters FIN; no word pulses.
- Words=1, only 2 bytes sent, TIMEOUT_CYCLES=100 -> o_timeout pulses 100 cycles after the last byte; no o_word_valid, no o_done; a new command is then accepted and completes normally.
- Second i_cmd_valid 0x05 while busy -> ignored; only the first command is transmitted. Reset asserted in RECV -> all outputs 0 the next cycle.
- With DEBUG_HOST_CHECKSUM_EN: words=1, bytes 0x11,0x22,0x33,0x44, checksum 0x44 -> o_done with o_checksum_err=0; the same bytes with checksum 0x00 -> o_checksum_err=1.
